// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit.
// Holds the FSM state encoding, the NOP instruction word, the default
// reset PC and a small alignment helper used by the next-PC selector.
package pc_fetch_unit_pkg;

  // FETCH: request outstanding; HOLD: instruction presented to decode;
  // TRAP: misaligned redirect seen, fetching stopped until reset.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_e;

  // RISC-V canonical NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A 32-bit instruction address must be word aligned.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selector for the fetch unit.
// Ports:
//   pc         - current program counter
//   target     - redirect address for the retiring instruction
//   redirect   - branch taken or jump at retire
//   next_pc    - target when redirecting, else pc+4 (wraps at 2^32)
//   misaligned - redirect requested to a non word-aligned target
module next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic        redirect,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] seq_pc_s;

  assign seq_pc_s = pc + 32'd4;

  // Select the sequential or redirect address and flag bad redirects.
  always_comb begin
    next_pc    = seq_pc_s;
    misaligned = 1'b0;
    if (redirect) begin
      next_pc    = target;
      misaligned = addr_misaligned(target);
    end else begin
      next_pc    = seq_pc_s;
      misaligned = 1'b0;
    end
  end

endmodule : next_pc_sel

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: issues one instruction-memory request at a time, holds
// the returned word for decode until it retires, then advances the PC
// sequentially or to a branch/jump target. A misaligned redirect parks
// the unit in TRAP with a sticky error flag until reset.
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   stall          - downstream cannot retire the held instruction
//   branch_taken   - branch decision, sampled at retire only
//   jump           - unconditional redirect, sampled at retire only
//   target_addr    - redirect address, sampled at retire only
//   imem_ack       - memory returns imem_rdata this cycle
//   imem_rdata     - instruction word
//   imem_req       - fetch request (FETCH state only)
//   imem_addr      - fetch address (= pc)
//   instr          - held instruction
//   instr_valid    - instr/pc valid for decode (HOLD state)
//   pc, pc_plus4   - current PC and its sequential successor
//   misaligned_err - sticky misaligned-redirect flag
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned_err
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic         instr_valid_r;
  logic         misaligned_err_r;

  logic         redirect_s;
  logic [31:0]  next_pc_s;
  logic         next_misaligned_s;

  assign redirect_s = branch_taken | jump;

  next_pc_sel u_next_pc_sel (
    .pc         (pc_r),
    .target     (target_addr),
    .redirect   (redirect_s),
    .next_pc    (next_pc_s),
    .misaligned (next_misaligned_s)
  );

  // Fetch FSM: request, hold for decode, retire or trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= FETCH;
      pc_r             <= RESET_PC;
      instr_r          <= NOP_INSTR;
      instr_valid_r    <= 1'b0;
      misaligned_err_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            instr_r       <= imem_rdata;
            instr_valid_r <= 1'b1;
            state_r       <= HOLD;
          end else begin
            state_r       <= FETCH;
          end
        end
        HOLD: begin
          // Redirect inputs only matter on the retire cycle (stall=0).
          if (!stall) begin
            instr_valid_r <= 1'b0;
            if (next_misaligned_s) begin
              misaligned_err_r <= 1'b1;
              state_r          <= TRAP;
            end else begin
              pc_r    <= next_pc_s;
              state_r <= FETCH;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        TRAP: begin
          instr_valid_r    <= 1'b0;
          misaligned_err_r <= 1'b1;
          state_r          <= TRAP;
        end
        default: begin
          // Unreachable encoding: stop fetching rather than run wild.
          instr_valid_r <= 1'b0;
          state_r       <= TRAP;
        end
      endcase
    end
  end

  // Request is gated by rst_n so it drops the moment reset asserts and
  // rises in the very first cycle after release.
  assign imem_req       = rst_n & (state_r == FETCH);
  assign imem_addr      = pc_r;
  assign instr          = instr_r;
  assign instr_valid    = instr_valid_r;
  assign pc             = pc_r;
  assign pc_plus4       = pc_r + 32'd4;
  assign misaligned_err = misaligned_err_r;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic [31:0] target_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .target_addr    (target_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  // Memory contents as a function of address (distinct per word).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One FETCH-state cycle at address a, with or without ack.
  task automatic fetch_cycle(input string tag, input logic [31:0] a, input logic ack);
    stall        = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    imem_ack     = ack;
    imem_rdata   = ack ? mem_word(a) : 32'hDEAD_BEEF;
    @(negedge clk);
    chk1({tag, "_req"}, imem_req, 1'b1);
    chk({tag, "_addr"}, imem_addr, a);
    chk1({tag, "_valid"}, instr_valid, 1'b0);
    tick();
  endtask

  // One HOLD-state cycle for the instruction fetched from a.
  task automatic hold_cycle(input string tag, input logic [31:0] a, input logic st,
                            input logic br, input logic jp, input logic [31:0] tgt);
    stall        = st;
    branch_taken = br;
    jump         = jp;
    target_addr  = tgt;
    imem_ack     = 1'b1;           // ack outside FETCH must be ignored
    imem_rdata   = 32'hBAD0_0BAD;
    @(negedge clk);
    chk1({tag, "_valid"}, instr_valid, 1'b1);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_pc"}, pc, a);
    chk({tag, "_instr"}, instr, mem_word(a));
    chk({tag, "_pc4"}, pc_plus4, a + 32'd4);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    target_addr = 32'h0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;

    // Reset state, with an ack present that must be ignored.
    @(negedge clk);
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0000_0013);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_err", misaligned_err, 1'b0);
    tick();
    rst_n = 1'b1;

    // Back-to-back fetches, one instruction per two cycles; a misaligned
    // target without redirect must not trap.
    for (int i = 0; i < 4; i++) begin
      fetch_cycle("seq_f", 32'(i * 4), 1'b1);
      hold_cycle("seq_h", 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0000_0103);
    end
    chk1("seq_noerr", misaligned_err, 1'b0);

    // Ack delayed three cycles at 0x10: address held for four cycles.
    for (int i = 0; i < 3; i++) fetch_cycle("dly_f", 32'h10, 1'b0);
    fetch_cycle("dly_ack", 32'h10, 1'b1);
    hold_cycle("dly_h", 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      fetch_cycle("run_f", 32'h14 + 32'(i * 4), 1'b1);
      hold_cycle("run_h", 32'h14 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0);
    end

    // Stall at 0x20 with branch toggling; only the release cycle counts.
    fetch_cycle("stl_f", 32'h20, 1'b1);
    for (int i = 0; i < 5; i++)
      hold_cycle("stl_h", 32'h20, 1'b1, (i % 2) == 0, 1'b0, 32'h0000_0200);
    hold_cycle("stl_rel", 32'h20, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    fetch_cycle("br_f", 32'h100, 1'b1);

    // Jump to the top of the address space, then wrap sequentially.
    hold_cycle("jtop_h", 32'h100, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch_cycle("top_f", 32'hFFFF_FFFC, 1'b1);
    hold_cycle("top_h", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_cycle("wrap_f", 32'h0000_0000, 1'b1);
    hold_cycle("wrap_h", 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0040);

    // Reset in the middle of a pending fetch at 0x40.
    fetch_cycle("mid_f", 32'h40, 1'b0);
    imem_ack = 1'b0;
    @(negedge clk);
    chk1("mid_req_before", imem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_req_drop", imem_req, 1'b0);
    chk("mid_pc_rst", pc, 32'h0000_0000);
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("mid_instr_nop", instr, 32'h0000_0013);
    chk1("mid_valid", instr_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    fetch_cycle("rst2_f", 32'h0, 1'b0);
    fetch_cycle("rst2_ack", 32'h0, 1'b1);

    // Misaligned jump at retire: trap, pc frozen, no more requests.
    hold_cycle("mis_h", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b0; jump = 1'b1; target_addr = 32'h0000_0008; imem_ack = 1'b1;
      @(negedge clk);
      chk1("trap_err", misaligned_err, 1'b1);
      chk1("trap_req", imem_req, 1'b0);
      chk1("trap_valid", instr_valid, 1'b0);
      chk("trap_pc", pc, 32'h0000_0000);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_fetch_unit
